mem_sram_ctrl: RTL and testbench

- MEM-stage data-memory controller; the producer side of the MEM/WB register.
- Takes the load/store request from EXE/MEM (`MEM_R_EN`, `MEM_W_EN`, byte address from `ALU_Res`, store value) and performs each 32-bit word access as two 16-bit half-word accesses on external asynchronous SRAM.
- Returns `Mem_read_value` and drives `ready`; the hazard/freeze logic stalls the pipeline while `ready` is low.

---
 rtl/mem_pkg.sv | 14 +
 rtl/mem_sram_ctrl.sv | 125 ++++++++++++
 tb/tb_mem_sram_ctrl.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared state encoding and widths for the MEM-stage SRAM controller
package mem_pkg;

    localparam int SRAM_DW = 16;
    localparam int WORD_W  = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } mem_state_e;

endpackage

// File: rtl/mem_sram_ctrl.sv
// rtl/mem_sram_ctrl.sv - MEM-stage load/store controller, one 32-bit word as two 16-bit SRAM accesses
module mem_sram_ctrl
    import mem_pkg::*;
#(
    parameter int BASE_ADDR     = 1024,
    parameter int ACCESS_CYCLES = 2,
    parameter int SRAM_AW       = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               MEM_R_EN,
    input  logic               MEM_W_EN,
    input  logic [31:0]        ALU_Res,
    input  logic [31:0]        ST_value,
    output logic               ready,
    output logic [31:0]        Mem_read_value,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_out,
    output logic               sram_dq_oe,
    input  logic [15:0]        sram_dq_in,
    output logic               sram_we_n
);

    localparam int                CW       = $clog2(ACCESS_CYCLES);
    localparam int                WAW      = SRAM_AW - 1;
    localparam logic [CW-1:0]     CNT_LAST = CW'(ACCESS_CYCLES - 1);

    mem_state_e          state, state_nxt;
    logic [CW-1:0]       cnt, cnt_nxt;
    logic [WAW-1:0]      word, word_nxt;
    logic                is_write, wr_nxt;
    logic [WORD_W-1:0]   st_data, st_nxt;
    logic [WORD_W-1:0]   addr_off;
    logic [SRAM_DW-1:0]  lo_half;
    logic                req, last, phase_nxt, hi_nxt;
    logic                unused_addr_bits;

    assign req      = MEM_R_EN | MEM_W_EN;
    assign last     = (cnt == CNT_LAST);
    assign addr_off = ALU_Res - 32'(BASE_ADDR);
    assign unused_addr_bits = ^{addr_off[WORD_W-1:SRAM_AW+1], addr_off[1:0]};

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        word_nxt  = word;
        wr_nxt    = is_write;
        st_nxt    = st_data;
        ready     = 1'b0;
        case (state)
            ST_IDLE: begin
                ready   = ~req;
                cnt_nxt = '0;
                if (req) begin
                    state_nxt = ST_LO;
                    wr_nxt    = MEM_W_EN;
                    word_nxt  = addr_off[SRAM_AW:2];
                    st_nxt    = ST_value;
                end
            end
            ST_LO: begin
                if (last) begin
                    state_nxt = ST_HI;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            ST_HI: begin
                if (last) begin
                    state_nxt = ST_DONE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            ST_DONE: begin
                ready     = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        phase_nxt = (state_nxt == ST_LO) || (state_nxt == ST_HI);
        hi_nxt    = (state_nxt == ST_HI);
    end

    // SRAM pins are registered from the next-state view so they are glitch-free and hold per phase
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= ST_IDLE;
            cnt            <= '0;
            word           <= '0;
            is_write       <= 1'b0;
            st_data        <= '0;
            lo_half        <= '0;
            Mem_read_value <= '0;
            sram_addr      <= '0;
            sram_dq_out    <= '0;
            sram_dq_oe     <= 1'b0;
            sram_we_n      <= 1'b1;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            word       <= word_nxt;
            is_write   <= wr_nxt;
            st_data    <= st_nxt;
            sram_dq_oe <= phase_nxt & wr_nxt;
            sram_we_n  <= ~(phase_nxt & wr_nxt & (cnt_nxt != CNT_LAST));
            if (phase_nxt) begin
                sram_addr <= {word_nxt, hi_nxt};
                if (wr_nxt) begin
                    sram_dq_out <= hi_nxt ? st_nxt[31:16] : st_nxt[15:0];
                end
            end
            // Low half is staged so the visible word only changes once the load completes
            if (state == ST_LO && last && !is_write) begin
                lo_half <= sram_dq_in;
            end
            if (state == ST_HI && last && !is_write) begin
                Mem_read_value <= {sram_dq_in, lo_half};
            end
        end
    end

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// tb/tb_mem_sram_ctrl.sv - randomized bench with behavioural SRAM and transaction-level reference model
module tb_mem_sram_ctrl;

    localparam int BASE = 1024;
    localparam int AC   = 2;
    localparam int AW   = 18;

    logic          clk = 1'b0;
    logic          rst;
    logic          MEM_R_EN, MEM_W_EN;
    logic [31:0]   ALU_Res, ST_value;
    logic          ready;
    logic [31:0]   Mem_read_value;
    logic [AW-1:0] sram_addr;
    logic [15:0]   sram_dq_out;
    logic          sram_dq_oe;
    logic [15:0]   sram_dq_in;
    logic          sram_we_n;

    mem_sram_ctrl #(.BASE_ADDR(BASE), .ACCESS_CYCLES(AC), .SRAM_AW(AW)) dut (
        .clk(clk), .rst(rst), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
        .ALU_Res(ALU_Res), .ST_value(ST_value), .ready(ready),
        .Mem_read_value(Mem_read_value), .sram_addr(sram_addr),
        .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
        .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [15:0] sram_mem [0:255];
    logic [15:0] ref_mem  [0:255];

    assign sram_dq_in = sram_mem[sram_addr[7:0]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Behavioural SRAM: a write strobe without the bus driven is a protocol error
    always @(negedge clk) begin
        if (rst && !sram_we_n) begin
            chk("we_n_low_needs_oe", 32'(sram_dq_oe), 32'd1);
            sram_mem[sram_addr[7:0]] = sram_dq_out;
        end
    end

    typedef struct {
        bit          done;
        bit          ld;
        logic [17:0] addr;
        bit          oe;
        bit          we_n;
        logic [15:0] dq;
        logic [31:0] val;
    } rec_t;

    rec_t        q[$];
    logic [31:0] exp_mrv = 32'd0;

    task automatic model_edge();
        rec_t        r;
        bit          wr;
        logic [31:0] off;
        logic [16:0] w;
        logic [7:0]  lo_i, hi_i;
        if (q.size() > 0) begin
            void'(q.pop_front());
        end else if (MEM_R_EN || MEM_W_EN) begin
            wr   = MEM_W_EN;
            off  = ALU_Res - BASE;
            w    = off[18:2];
            lo_i = {w[6:0], 1'b0};
            hi_i = {w[6:0], 1'b1};
            if (wr) begin
                ref_mem[lo_i] = ST_value[15:0];
                ref_mem[hi_i] = ST_value[31:16];
            end
            for (int p = 0; p < 2; p++) begin
                for (int c = 0; c < AC; c++) begin
                    r.done = 0;
                    r.ld   = 0;
                    r.addr = {w, p[0]};
                    r.oe   = wr;
                    r.we_n = !(wr && c < AC - 1);
                    r.dq   = p ? ST_value[31:16] : ST_value[15:0];
                    r.val  = 32'd0;
                    q.push_back(r);
                end
            end
            r.done = 1;
            r.ld   = !wr;
            r.val  = {ref_mem[hi_i], ref_mem[lo_i]};
            q.push_back(r);
        end
    endtask

    task automatic compare();
        rec_t e;
        if (q.size() > 0) begin
            e = q[0];
            if (e.done) begin
                if (e.ld) exp_mrv = e.val;
                chk("ready_done", 32'(ready), 32'd1);
                chk("oe_done", 32'(sram_dq_oe), 32'd0);
                chk("we_n_done", 32'(sram_we_n), 32'd1);
            end else begin
                chk("ready_busy", 32'(ready), 32'd0);
                chk("sram_addr", 32'(sram_addr), 32'(e.addr));
                chk("sram_dq_oe", 32'(sram_dq_oe), 32'(e.oe));
                chk("sram_we_n", 32'(sram_we_n), 32'(e.we_n));
                if (e.oe) chk("sram_dq_out", 32'(sram_dq_out), 32'(e.dq));
            end
        end else begin
            chk("ready_idle", 32'(ready), 32'(!(MEM_R_EN || MEM_W_EN)));
        end
        chk("mem_read_value", Mem_read_value, exp_mrv);
    endtask

    task automatic cycle();
        if (rst) model_edge();
        @(posedge clk);
        @(negedge clk);
        if (rst) compare();
    endtask

    task automatic wait_done(output int low_cnt, output logic [3:0] we_pat);
        bit got;
        got     = 0;
        low_cnt = 0;
        we_pat  = 4'd0;
        for (int i = 0; i < 40 && !got; i++) begin
            cycle();
            if (q.size() > 0 && !q[0].done) begin
                low_cnt++;
                we_pat = {we_pat[2:0], sram_we_n};
            end
            if (q.size() == 1 && q[0].done) got = 1;
        end
        if (!got) chk("access_timeout", 32'd1, 32'd0);
    endtask

    task automatic do_req(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
        int         lc;
        logic [3:0] wp;
        MEM_R_EN = r;
        MEM_W_EN = w;
        ALU_Res  = a;
        ST_value = d;
        wait_done(lc, wp);
        MEM_R_EN = 0;
        MEM_W_EN = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        int         lc;
        logic [3:0] wp;
        int         bad;
        for (int i = 0; i < 256; i++) begin
            sram_mem[i] = 16'h0;
            ref_mem[i]  = 16'h0;
        end
        rst      = 1'b0;
        MEM_R_EN = 1'b0;
        MEM_W_EN = 1'b1;
        ALU_Res  = 32'd1028;
        ST_value = 32'hDEADBEEF;
        @(negedge clk);
        @(negedge clk);
        chk("rst_we_n", 32'(sram_we_n), 32'd1);
        chk("rst_oe", 32'(sram_dq_oe), 32'd0);
        chk("rst_mrv", Mem_read_value, 32'd0);
        chk("rst_ready", 32'(ready), 32'd0);
        rst = 1'b1;
        wait_done(lc, wp);
        MEM_W_EN = 1'b0;
        chk("store_ready_low_cycles", 32'(lc), 32'd4);
        chk("store_we_n_pattern", 32'(wp), 32'b0101);
        chk("sram2_beef", 32'(sram_mem[2]), 32'h0000BEEF);
        chk("sram3_dead", 32'(sram_mem[3]), 32'h0000DEAD);
        idle(2);

        do_req(1, 0, 32'd1028, 32'h0);
        chk("load_1028", Mem_read_value, 32'hDEADBEEF);
        idle(3);
        chk("load_1028_held", Mem_read_value, 32'hDEADBEEF);

        do_req(0, 1, 32'd1024, 32'h12345678);
        do_req(0, 1, 32'd1032, 32'hCAFEF00D);
        chk("store_keeps_mrv", Mem_read_value, 32'hDEADBEEF);
        do_req(1, 0, 32'd1024, 32'h0);
        chk("load_1024", Mem_read_value, 32'h12345678);
        do_req(1, 0, 32'd1032, 32'h0);
        chk("load_1032", Mem_read_value, 32'hCAFEF00D);
        chk("sram2_unchanged", 32'(sram_mem[2]), 32'h0000BEEF);
        chk("sram3_unchanged", 32'(sram_mem[3]), 32'h0000DEAD);

        do_req(1, 1, 32'd1036, 32'hA5A5A5A5);
        chk("both_en_mrv_kept", Mem_read_value, 32'hCAFEF00D);
        chk("both_en_sram7", 32'(sram_mem[7]), 32'h0000A5A5);
        do_req(1, 0, 32'd1036, 32'h0);
        chk("load_1036", Mem_read_value, 32'hA5A5A5A5);
        idle(1);

        MEM_R_EN = 1'b1;
        ALU_Res  = 32'd1032;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (q.size() > 0 && !q[0].done && q.size() <= AC + 1) break;
        end
        chk("reached_hi_phase", 32'(q.size() > 0 && q.size() <= AC + 1), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("midrst_mrv", Mem_read_value, 32'd0);
        chk("midrst_we_n", 32'(sram_we_n), 32'd1);
        chk("midrst_oe", 32'(sram_dq_oe), 32'd0);
        chk("midrst_ready", 32'(ready), 32'd0);
        q.delete();
        exp_mrv = 32'd0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        wait_done(lc, wp);
        MEM_R_EN = 1'b0;
        chk("load_after_rst", Mem_read_value, 32'hCAFEF00D);
        idle(1);

        for (int n = 0; n < 60; n++) begin
            int          op;
            logic [31:0] a;
            op = $urandom_range(0, 2);
            a  = BASE + 4 * $urandom_range(0, 15) + $urandom_range(0, 3);
            do_req(op != 1, op != 0, a, $urandom);
            idle($urandom_range(0, 2));
        end

        bad = 0;
        for (int i = 0; i < 128; i++) if (sram_mem[i] !== ref_mem[i]) bad++;
        chk("sram_contents_mismatches", 32'(bad), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
